alarm_ctrl: RTL and testbench
=============================

Name: alarm_ctrl

Overview:
- Alarm stage downstream of the hour/minute/second counter block. It consumes the live sec/min/hr counts and a one-cycle second tick, and it holds a settable alarm time.
- Runs a disarmed/armed/ringing/snooze state machine and drives a square-wave buzzer output.
- Alarm hour/minute are exported so the display path can show them in alarm-set mode.

Parameters:
- TONE_DIV, 32'd25000, clk cycles per buzzer half-period (1 kHz tone at 50 MHz)
- RING_SEC, 9'd60, seconds of ringing before auto-return to ARMED
- SNOOZE_SEC, 9'd300, seconds of snooze before ringing resumes

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- i_sec  input  6  current seconds, 0..59
- i_min  input  6  current minutes, 0..59
- i_hr  input  6  current hours, 0..23
- i_sec_tick  input  1  one-clk pulse per elapsed second, synchronous to clk
- i_arm  input  1  one-clk pulse; toggles armed/disarmed
- i_inc_min  input  1  one-clk pulse; alarm minute +1
- i_inc_hr  input  1  one-clk pulse; alarm hour +1
- i_stop  input  1  one-clk pulse; stop ringing
- i_snooze  input  1  one-clk pulse; snooze while ringing
- o_alarm_min  output  6  alarm minute
- o_alarm_hr  output  6  alarm hour
- o_state  output  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
- o_buzz  output  1  buzzer drive, registered

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_alarm_min=0, o_alarm_hr=0
  - state IDLE, o_buzz=0
  - tone counter=0, second counter=0
  - match_d (registered previous match)=0
- All inputs are sampled on the rising clk edge.
- Alarm time edit:
  - i_inc_min increments o_alarm_min; 59 wraps to 0 and does not carry into the hour.
  - i_inc_hr increments o_alarm_hr; 23 wraps to 0.
  - Edits are accepted in any state and take effect the next cycle.
- Match logic:
  - match = (i_hr==o_alarm_hr) && (i_min==o_alarm_min) && (i_sec==0), combinational.
  - match_d is the registered copy of match.
  - trigger = match && !match_d.
- State transitions (evaluated each clk):
  - IDLE:
    - i_arm -> ARMED.
    - trigger is ignored.
  - ARMED:
    - i_arm -> IDLE.
    - Otherwise trigger -> RINGING, second counter cleared.
  - RINGING:
    - Priority order: i_arm -> IDLE; i_stop -> ARMED; i_snooze -> SNOOZE with second counter cleared.
    - On i_sec_tick the second counter increments. When the counter reaches RING_SEC-1 on a tick -> ARMED.
  - SNOOZE:
    - i_arm -> IDLE; i_stop -> ARMED.
    - On i_sec_tick the second counter increments. When the counter reaches SNOOZE_SEC-1 on a tick -> RINGING with the counter cleared. This does not depend on the time match.
- Simultaneous events:
  - i_arm has priority over everything else, then i_stop, then i_snooze, then timeouts/trigger.
  - Alarm-time edits are independent of state changes and apply in the same cycle.
- Buzzer:
  - Only in RINGING, the tone counter counts 0..TONE_DIV-1. At TONE_DIV-1 it returns to 0 and o_buzz toggles.
  - On leaving RINGING, o_buzz is forced to 0 and the tone counter to 0 on the same edge, so o_buzz=0 in the cycle after the state change.
- Edge-detected trigger: one alarm-time occurrence produces at most one ring, even if stopped within the matching second.
- A hold-off of one clk applies after a time edit that creates a match mid-second. The match rises, so the alarm triggers if ARMED.
- Reset mid-ring: the next cycle is IDLE with o_buzz=0, and the alarm time returns to 00:00.
- o_state is the registered state.

Optional Feature:
- Macro ALARM_BEEP_PATTERN_EN.
- Defined:
  - While RINGING, o_buzz is additionally gated off during odd-numbered seconds of the ring counter, giving a 1 s on / 1 s off beep.
  - The tone counter keeps running during the gated seconds.
- Undefined: continuous tone throughout RINGING.

Test Plan:
- Reset, then apply i_inc_hr x7 and i_inc_min x30, then i_arm -> o_alarm_hr=7, o_alarm_min=30, o_state=01.
- ARMED at alarm 07:30; drive time 07:29:59 then 07:30:00 -> o_state=10 one cycle later, o_buzz toggles every TONE_DIV clks (TONE_DIV=4 in the bench).
- RINGING with 60 i_sec_tick pulses and no stop (RING_SEC=60) -> o_state=01 after the 60th tick, o_buzz=0; time held at 07:30:00 does not re-trigger.
- RINGING, i_snooze, then 300 ticks (SNOOZE_SEC=300) -> o_state=11 then 10 after the 300th tick; i_stop -> 01, o_buzz=0 next cycle.
- RINGING with i_arm and i_stop in the same cycle -> o_state=00; i_inc_min at o_alarm_min=59 -> 0 and o_alarm_hr unchanged; i_inc_hr at 23 -> 0.
- rst asserted while RINGING -> next cycle o_state=00, o_buzz=0, alarm time 00:00. With ALARM_BEEP_PATTERN_EN defined, o_buzz is 0 throughout ring-counter seconds 1, 3, 5.

Source files
------------

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm time register, arm/ring/snooze FSM and buzzer tone generator
//
// Purpose:
//   Holds a settable alarm time and compares it against the live time-of-day
//   counts. A rising match (time reaches hh:mm:00) while ARMED starts RINGING.
//   RINGING auto-returns to ARMED after RING_SEC seconds. SNOOZE resumes
//   RINGING after SNOOZE_SEC seconds. While ringing, o_buzz is a square wave
//   with a half-period of TONE_DIV clocks.
//
// Optional feature macro: ALARM_BEEP_PATTERN_EN
//   When defined, o_buzz is gated off during odd-numbered ring seconds
//   (1 s on / 1 s off). The tone counter keeps running while gated.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   i_sec        current seconds, 0..59
//   i_min        current minutes, 0..59
//   i_hr         current hours, 0..23
//   i_sec_tick   one-clk pulse per elapsed second
//   i_arm        one-clk pulse, toggles armed/disarmed
//   i_inc_min    one-clk pulse, alarm minute +1 (wraps 59->0, no carry)
//   i_inc_hr     one-clk pulse, alarm hour +1 (wraps 23->0)
//   i_stop       one-clk pulse, stop ringing/snooze and return to ARMED
//   i_snooze     one-clk pulse, snooze while ringing
//   o_alarm_min  alarm minute
//   o_alarm_hr   alarm hour
//   o_state      00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
//   o_buzz       buzzer drive

module alarm_ctrl #(
    parameter logic [31:0] TONE_DIV   = 32'd25000,
    parameter logic [8:0]  RING_SEC   = 9'd60,
    parameter logic [8:0]  SNOOZE_SEC = 9'd300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [5:0] i_hr,
    input  logic       i_sec_tick,
    input  logic       i_arm,
    input  logic       i_inc_min,
    input  logic       i_inc_hr,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic [5:0] o_alarm_min,
    output logic [5:0] o_alarm_hr,
    output logic [1:0] o_state,
    output logic       o_buzz
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZE  = 2'b11
    } state_t;

    state_t      r_state;
    logic [5:0]  r_alarm_min;
    logic [5:0]  r_alarm_hr;
    logic        r_buzz;
    logic [31:0] r_tone_cnt;
    logic [8:0]  r_sec_cnt;
    logic        r_match_d;

    logic w_match;
    logic w_trigger;
    logic w_ring_timeout;
    logic w_snooze_timeout;
    logic w_stay_ringing;
    logic w_tone_wrap;

    assign w_match          = (i_hr == r_alarm_hr) && (i_min == r_alarm_min) && (i_sec == 6'd0);
    // Edge detect so a match lasting a whole second rings at most once.
    assign w_trigger        = w_match && !r_match_d;
    assign w_ring_timeout   = i_sec_tick && (r_sec_cnt == RING_SEC - 9'd1);
    assign w_snooze_timeout = i_sec_tick && (r_sec_cnt == SNOOZE_SEC - 9'd1);
    assign w_tone_wrap      = (r_tone_cnt == TONE_DIV - 32'd1);

    // True when the FSM remains in RINGING across this edge; anything else
    // clears the tone generator on the same edge as the state change.
    assign w_stay_ringing = (r_state == S_RINGING) && !i_arm && !i_stop
                            && !i_snooze && !w_ring_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_alarm_min <= 6'd0;
            r_alarm_hr  <= 6'd0;
            r_buzz      <= 1'b0;
            r_tone_cnt  <= 32'd0;
            r_sec_cnt   <= 9'd0;
            r_match_d   <= 1'b0;
        end else begin
            r_match_d <= w_match;

            // Alarm time edits are independent of the FSM.
            if (i_inc_min) begin
                r_alarm_min <= (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
            end
            if (i_inc_hr) begin
                r_alarm_hr <= (r_alarm_hr == 6'd23) ? 6'd0 : r_alarm_hr + 6'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_arm) begin
                        r_state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (i_arm) begin
                        r_state <= S_IDLE;
                    end else if (w_trigger) begin
                        r_state   <= S_RINGING;
                        r_sec_cnt <= 9'd0;
                    end
                end
                S_RINGING: begin
                    if (i_arm) begin
                        r_state <= S_IDLE;
                    end else if (i_stop) begin
                        r_state <= S_ARMED;
                    end else if (i_snooze) begin
                        r_state   <= S_SNOOZE;
                        r_sec_cnt <= 9'd0;
                    end else if (w_ring_timeout) begin
                        r_state <= S_ARMED;
                    end else if (i_sec_tick) begin
                        r_sec_cnt <= r_sec_cnt + 9'd1;
                    end
                end
                S_SNOOZE: begin
                    if (i_arm) begin
                        r_state <= S_IDLE;
                    end else if (i_stop) begin
                        r_state <= S_ARMED;
                    end else if (w_snooze_timeout) begin
                        r_state   <= S_RINGING;
                        r_sec_cnt <= 9'd0;
                    end else if (i_sec_tick) begin
                        r_sec_cnt <= r_sec_cnt + 9'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_stay_ringing) begin
                if (w_tone_wrap) begin
                    r_tone_cnt <= 32'd0;
                    r_buzz     <= ~r_buzz;
                end else begin
                    r_tone_cnt <= r_tone_cnt + 32'd1;
                end
            end else begin
                r_tone_cnt <= 32'd0;
                r_buzz     <= 1'b0;
            end
        end
    end

    assign o_alarm_min = r_alarm_min;
    assign o_alarm_hr  = r_alarm_hr;
    assign o_state     = r_state;

`ifdef ALARM_BEEP_PATTERN_EN
    // r_buzz is already 0 outside RINGING, so only the ring-second parity
    // needs to gate it.
    assign o_buzz = r_buzz & ~r_sec_cnt[0];
`else
    assign o_buzz = r_buzz;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl

module tb_alarm_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] i_sec, i_min, i_hr;
    logic       i_sec_tick, i_arm, i_inc_min, i_inc_hr, i_stop, i_snooze;
    logic [5:0] o_alarm_min, o_alarm_hr;
    logic [1:0] o_state;
    logic       o_buzz;

    int n_cmp  = 0;
    int n_fail = 0;

    alarm_ctrl #(
        .TONE_DIV   (32'd4),
        .RING_SEC   (9'd60),
        .SNOOZE_SEC (9'd300)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sec       (i_sec),
        .i_min       (i_min),
        .i_hr        (i_hr),
        .i_sec_tick  (i_sec_tick),
        .i_arm       (i_arm),
        .i_inc_min   (i_inc_min),
        .i_inc_hr    (i_inc_hr),
        .i_stop      (i_stop),
        .i_snooze    (i_snooze),
        .o_alarm_min (o_alarm_min),
        .o_alarm_hr  (o_alarm_hr),
        .o_state     (o_state),
        .o_buzz      (o_buzz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       arm, inc_min, inc_hr, stop, snooze, tick;
        logic [5:0] hr, mn, sc;
        logic [1:0] st;
        logic [5:0] ahr, amin;
        logic       chk_buzz;
        logic       buzz;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic arm, input logic inc_min, input logic inc_hr,
                                input logic stop, input logic snooze, input logic tick,
                                input logic [5:0] hr, input logic [5:0] mn, input logic [5:0] sc,
                                input logic [1:0] st, input logic [5:0] ahr, input logic [5:0] amin,
                                input logic chk_buzz, input logic buzz);
        vec_t v;
        v.arm = arm; v.inc_min = inc_min; v.inc_hr = inc_hr; v.stop = stop;
        v.snooze = snooze; v.tick = tick; v.hr = hr; v.mn = mn; v.sc = sc;
        v.st = st; v.ahr = ahr; v.amin = amin; v.chk_buzz = chk_buzz; v.buzz = buzz;
        vecs.push_back(v);
    endfunction

    // Apply one cycle of inputs (driven away from the rising edge), then
    // sample the registered outputs 1 time unit after the edge.
    task automatic step(input logic arm, input logic inc_min, input logic inc_hr,
                        input logic stop, input logic snooze, input logic tick,
                        input logic [5:0] hr, input logic [5:0] mn, input logic [5:0] sc);
        @(negedge clk);
        i_arm = arm; i_inc_min = inc_min; i_inc_hr = inc_hr;
        i_stop = stop; i_snooze = snooze; i_sec_tick = tick;
        i_hr = hr; i_min = mn; i_sec = sc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [5:0] hr, input logic [5:0] mn, input logic [5:0] sc);
        step(0, 0, 0, 0, 0, 0, hr, mn, sc);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        i_arm = 0; i_inc_min = 0; i_inc_hr = 0; i_stop = 0; i_snooze = 0; i_sec_tick = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        i_sec = 6'd0; i_min = 6'd0; i_hr = 6'd12;
        i_sec_tick = 0; i_arm = 0; i_inc_min = 0; i_inc_hr = 0; i_stop = 0; i_snooze = 0;

        // Setup and first trigger as a vector table.
        for (int k = 1; k <= 7; k++)
            add(0, 0, 1, 0, 0, 0, 6'd12, 6'd0, 6'd0, 2'b00, 6'(k), 6'd0, 1, 0);
        for (int k = 1; k <= 30; k++)
            add(0, 1, 0, 0, 0, 0, 6'd12, 6'd0, 6'd0, 2'b00, 6'd7, 6'(k), 1, 0);
        add(1, 0, 0, 0, 0, 0, 6'd12, 6'd0,  6'd0,  2'b01, 6'd7, 6'd30, 1, 0);
        add(0, 0, 0, 0, 0, 0, 6'd7,  6'd29, 6'd59, 2'b01, 6'd7, 6'd30, 1, 0);
        add(0, 0, 0, 0, 0, 0, 6'd7,  6'd30, 6'd0,  2'b10, 6'd7, 6'd30, 1, 0);
        // Tone: half-period of 4 clocks starting low.
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 0);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 0);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 0);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 1);
        add(0, 0, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0, 2'b10, 6'd7, 6'd30, 1, 0);

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", 0, o_state, 0);
        chk("rst_amin", 0, o_alarm_min, 0);
        chk("rst_ahr", 0, o_alarm_hr, 0);
        chk("rst_buzz", 0, o_buzz, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].arm, vecs[i].inc_min, vecs[i].inc_hr, vecs[i].stop,
                 vecs[i].snooze, vecs[i].tick, vecs[i].hr, vecs[i].mn, vecs[i].sc);
            chk("vec_state", i, o_state, vecs[i].st);
            chk("vec_ahr", i, o_alarm_hr, vecs[i].ahr);
            chk("vec_amin", i, o_alarm_min, vecs[i].amin);
            if (vecs[i].chk_buzz) chk("vec_buzz", i, o_buzz, vecs[i].buzz);
        end

        // Ring timeout after 60 ticks; held match must not retrigger.
        for (int k = 1; k <= 60; k++) begin
            step(0, 0, 0, 0, 0, 1, 6'd7, 6'd30, 6'd0);
            if (k == 59) chk("ring_59", k, o_state, 2);
            if (k == 60) begin
                chk("ring_to_state", k, o_state, 1);
                chk("ring_to_buzz", k, o_buzz, 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            idle(6'd7, 6'd30, 6'd0);
            chk("no_retrigger", k, o_state, 1);
        end

        // Snooze then resume, then stop.
        idle(6'd7, 6'd30, 6'd1);
        chk("pre_snz", 0, o_state, 1);
        idle(6'd7, 6'd30, 6'd0);
        chk("ring2", 0, o_state, 2);
        for (int k = 0; k < 4; k++) idle(6'd7, 6'd30, 6'd0);
        chk("ring2_buzz", 0, o_buzz, 1);
        step(0, 0, 0, 0, 1, 0, 6'd7, 6'd30, 6'd0);
        chk("snz_state", 0, o_state, 3);
        chk("snz_buzz", 0, o_buzz, 0);
        for (int k = 1; k <= 300; k++) begin
            step(0, 0, 0, 0, 0, 1, 6'd7, 6'd30, 6'd0);
            if (k == 299) chk("snz_299", k, o_state, 3);
            if (k == 300) chk("snz_to_ring", k, o_state, 2);
        end
        for (int k = 0; k < 4; k++) idle(6'd7, 6'd30, 6'd0);
        chk("ring3_buzz", 0, o_buzz, 1);
        step(0, 0, 0, 1, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("stop_state", 0, o_state, 1);
        chk("stop_buzz", 0, o_buzz, 0);

        // Arm and stop together: arm wins.
        idle(6'd7, 6'd30, 6'd1);
        idle(6'd7, 6'd30, 6'd0);
        chk("ring4", 0, o_state, 2);
        step(1, 0, 0, 1, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("arm_stop", 0, o_state, 0);

        // Minute and hour wrap.
        for (int k = 0; k < 29; k++) step(0, 1, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("amin_59", 0, o_alarm_min, 59);
        step(0, 1, 0, 0, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("amin_wrap", 0, o_alarm_min, 0);
        chk("amin_wrap_hr", 0, o_alarm_hr, 7);
        for (int k = 0; k < 16; k++) step(0, 0, 1, 0, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("ahr_23", 0, o_alarm_hr, 23);
        step(0, 0, 1, 0, 0, 0, 6'd7, 6'd30, 6'd0);
        chk("ahr_wrap", 0, o_alarm_hr, 0);
        chk("ahr_wrap_min", 0, o_alarm_min, 0);

        // Match while IDLE is ignored.
        idle(6'd0, 6'd0, 6'd59);
        idle(6'd0, 6'd0, 6'd0);
        chk("idle_ignore", 0, o_state, 0);

        // Edit that creates a match mid-second triggers one clock later.
        idle(6'd0, 6'd5, 6'd0);
        step(1, 0, 0, 0, 0, 0, 6'd0, 6'd5, 6'd0);
        chk("arm2", 0, o_state, 1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0, 6'd0, 6'd5, 6'd0);
        chk("edit_amin4", 0, o_alarm_min, 4);
        step(0, 1, 0, 0, 0, 0, 6'd0, 6'd5, 6'd0);
        chk("edit_holdoff", 0, o_state, 1);
        idle(6'd0, 6'd5, 6'd0);
        chk("edit_trigger", 0, o_state, 2);
        for (int k = 0; k < 4; k++) idle(6'd0, 6'd5, 6'd0);
        chk("ring5_buzz", 0, o_buzz, 1);

        // Reset mid-ring.
        do_reset();
        chk("rst2_state", 0, o_state, 0);
        chk("rst2_buzz", 0, o_buzz, 0);
        chk("rst2_amin", 0, o_alarm_min, 0);
        chk("rst2_ahr", 0, o_alarm_hr, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ALARM_BEEP_PATTERN_EN
        idle(6'd0, 6'd0, 6'd1);
        step(1, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd1);
        idle(6'd0, 6'd0, 6'd0);
        chk("beep_ring", 0, o_state, 2);
        for (int s = 1; s <= 5; s++) begin
            logic seen_high;
            seen_high = 1'b0;
            step(0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 6'd0);
            for (int k = 0; k < 9; k++) begin
                if (s % 2 == 1) chk("beep_gated", s, o_buzz, 0);
                else if (o_buzz) seen_high = 1'b1;
                idle(6'd0, 6'd0, 6'd0);
            end
            if (s % 2 == 0) chk("beep_on", s, seen_high, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
